// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: default sizes, clog2 and the
// parameter legality rule every FIFO variant checks at elaboration.
package fifo_pkg;

  localparam int FIFO_DEF_DATA_W = 8;
  localparam int FIFO_DEF_DEPTH  = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  // AF_LEVEL must be reachable (1..DEPTH); AE_LEVEL must leave room to be non-almost-empty.
  function automatic bit fifo_params_ok(input int data_w, input int depth,
                                        input int af_level, input int ae_level);
    return (data_w >= 1) && is_pow2(depth) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read sees the pre-edge contents, so a same-cycle write never bypasses to it.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy count, flags, overflow/underflow
// pulses and the standard-registered / first-word-fall-through read path.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W   = FIFO_DEF_DATA_W,
  parameter int DEPTH    = FIFO_DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              we,
  input  logic              re,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
);

  if (!fifo_params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
    $error("sync_fifo_ctrl: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_CNT    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_CNT    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_ok, wr_ok;
  logic [DATA_W-1:0] ram_rdata;

  // Flags decode from the count register alone.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_CNT);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    rd_ok       = re && !empty;
    // A full FIFO still takes a write when a read frees the slot on the same edge.
    wr_ok       = we && (!full || re);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = we && !wr_ok;
    underflow_d = re && !rd_ok;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rdata)
  );

  if (FWFT == 0) begin : g_std
    logic [DATA_W-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_ok) dout_d = ram_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= dout_d;
    end

    assign data_out = dout_q;
  end else begin : g_fwft
    // Head word is presented as soon as it exists; re pops it.
    assign data_out = empty ? '0 : ram_rdata;
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench: a standard-mode and an FWFT instance share stimulus and are
// compared against a queue-based reference model, a directed table and corner sequences.
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] s_dout, f_dout;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] s_count, f_count;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.DATA_W(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .we(we), .re(re),
    .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_ctrl #(.DATA_W(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .we(we), .re(re),
    .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  // Reference model: contents as a queue, plus the standard-mode output register and pulses.
  logic [7:0] mq[$];
  logic [7:0] m_std = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic compare_all(input string tag);
    int         sz;
    logic [7:0] fw;
    sz = mq.size();
    fw = (sz > 0) ? mq[0] : 8'h00;
    check({tag, " s_count"}, 32'(s_count), 32'(sz));
    check({tag, " f_count"}, 32'(f_count), 32'(sz));
    check({tag, " s_empty"}, 32'(s_empty), 32'(sz == 0));
    check({tag, " f_empty"}, 32'(f_empty), 32'(sz == 0));
    check({tag, " s_full"},  32'(s_full),  32'(sz == DEPTH));
    check({tag, " f_full"},  32'(f_full),  32'(sz == DEPTH));
    check({tag, " s_af"},    32'(s_af),    32'(sz >= AF));
    check({tag, " f_af"},    32'(f_af),    32'(sz >= AF));
    check({tag, " s_ae"},    32'(s_ae),    32'(sz <= AE));
    check({tag, " f_ae"},    32'(f_ae),    32'(sz <= AE));
    check({tag, " s_ovf"},   32'(s_ovf),   32'(m_ovf));
    check({tag, " f_ovf"},   32'(f_ovf),   32'(m_ovf));
    check({tag, " s_unf"},   32'(s_unf),   32'(m_unf));
    check({tag, " f_unf"},   32'(f_unf),   32'(m_unf));
    check({tag, " s_dout"},  32'(s_dout),  32'(m_std));
    check({tag, " f_dout"},  32'(f_dout),  32'(fw));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, " s_count"}, 32'(s_count), 32'd0);
    check({tag, " f_count"}, 32'(f_count), 32'd0);
    check({tag, " s_empty"}, 32'(s_empty), 32'd1);
    check({tag, " s_full"},  32'(s_full),  32'd0);
    check({tag, " s_ae"},    32'(s_ae),    32'd1);
    check({tag, " s_af"},    32'(s_af),    32'd0);
    check({tag, " s_ovf"},   32'(s_ovf),   32'd0);
    check({tag, " s_unf"},   32'(s_unf),   32'd0);
    check({tag, " s_dout"},  32'(s_dout),  32'd0);
    check({tag, " f_dout"},  32'(f_dout),  32'd0);
  endtask

  // One transaction: drive, clock, advance the model, compare, log.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input string tag);
    int   sz;
    logic rok, wok;
    we = w; re = r; data_in = d;
    @(posedge clk);
    #1;
    sz  = mq.size();
    rok = r && (sz > 0);
    wok = w && ((sz < DEPTH) || r);
    if (rok) m_std = mq.pop_front();
    if (wok) mq.push_back(d);
    m_ovf = w && !wok;
    m_unf = r && !rok;
    compare_all(tag);
    $display("[%0t] %s we=%0b re=%0b din=%02h -> cnt=%0d dout=%02h/%02h ovf=%0b unf=%0b",
             $time, tag, w, r, d, s_count, s_dout, f_dout, s_ovf, s_unf);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1 && mq.size() > 0; i++) step(1'b0, 1'b1, 8'h00, "drain");
  endtask

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    int         cnt;
    logic       emp;
    logic       unf;
    logic [7:0] sd;
    logic [7:0] fd;
  } tv_t;

  tv_t tv [9];

  initial begin
    // Directed vectors from reset: {we, re, din, count, empty, underflow, std dout, fwft dout}
    tv[0] = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 8'h00, 8'h11};
    tv[1] = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 8'h00, 8'h11};
    tv[2] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 8'h11, 8'h22};
    tv[3] = '{1'b1, 1'b1, 8'h33, 1, 1'b0, 1'b0, 8'h22, 8'h33};
    tv[4] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h33, 8'h00};
    tv[5] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 8'h33, 8'h00};
    tv[6] = '{1'b1, 1'b1, 8'h55, 1, 1'b0, 1'b1, 8'h33, 8'h55};
    tv[7] = '{1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 8'h33, 8'h55};
    tv[8] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h55, 8'h00};

    #12;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(tv[i].w, tv[i].r, tv[i].d, $sformatf("tv%0d", i));
      check($sformatf("tv%0d count", i), 32'(s_count), 32'(tv[i].cnt));
      check($sformatf("tv%0d empty", i), 32'(s_empty), 32'(tv[i].emp));
      check($sformatf("tv%0d unf", i),   32'(s_unf),   32'(tv[i].unf));
      check($sformatf("tv%0d sdout", i), 32'(s_dout),  32'(tv[i].sd));
      check($sformatf("tv%0d fdout", i), 32'(f_dout),  32'(tv[i].fd));
    end

    // Fill 0x01..0x10, then a lone write into a full FIFO.
    drain();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, 8'(i), "fill");
      check($sformatf("fill%0d af", i), 32'(s_af), 32'(i >= 14));
    end
    check("fill full", 32'(s_full), 32'd1);
    step(1'b1, 1'b0, 8'hEE, "ovf");
    check("ovf pulse", 32'(s_ovf), 32'd1);
    check("ovf count", 32'(s_count), 32'd16);
    step(1'b0, 1'b0, 8'h00, "idle");
    check("ovf clears", 32'(s_ovf), 32'd0);

    // Read back in order, then one read too many.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00, "read");
      check($sformatf("read%0d data", i), 32'(s_dout), 32'(i));
    end
    step(1'b0, 1'b1, 8'h00, "unf");
    check("unf pulse", 32'(s_unf), 32'd1);
    check("unf dout hold", 32'(s_dout), 32'h10);
    check("unf empty", 32'(s_empty), 32'd1);

    // Simultaneous write+read on a full FIFO.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h80 + i), "fill2");
    step(1'b1, 1'b1, 8'hAA, "full_wr_rd");
    check("full_wr_rd count", 32'(s_count), 32'd16);
    check("full_wr_rd ovf", 32'(s_ovf), 32'd0);
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00, "read2");
      if (i == DEPTH) check("AA emerges 16th", 32'(s_dout), 32'hAA);
    end

    // Simultaneous write+read on an empty FIFO.
    step(1'b1, 1'b1, 8'h55, "empty_wr_rd");
    check("empty_wr_rd unf", 32'(s_unf), 32'd1);
    check("empty_wr_rd count", 32'(s_count), 32'd1);
    check("empty_wr_rd fwft", 32'(f_dout), 32'h55);
    step(1'b0, 1'b1, 8'h00, "read55");
    check("read55 sdout", 32'(s_dout), 32'h55);

    // Pointer wrap with varying occupancy.
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0, 8'($urandom), "wrap_w");
      step(1'b0, (mq.size() > (k % 12)) ? 1'b1 : 1'b0, 8'h00, "wrap_r");
    end

    // Randomised traffic, bias shifting between fill-heavy, balanced and drain-heavy.
    for (int c = 0; c < 300; c++) begin
      int pw;
      pw = ((c / 50) % 3 == 0) ? 85 : (((c / 50) % 3 == 1) ? 50 : 15);
      step(($urandom_range(0, 99) < pw) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < (100 - pw)) ? 1'b1 : 1'b0,
           8'($urandom), "rand");
    end

    // Asynchronous reset with 9 entries held.
    drain();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h90 + i), "pre_rst");
    check("pre_rst count", 32'(s_count), 32'd9);
    we = 1'b0; re = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    mq.delete();
    m_std = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("arst_hold");
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'hC3, "post_rst_w");
    check("post_rst fwft", 32'(f_dout), 32'hC3);
    check("post_rst count", 32'(s_count), 32'd1);
    step(1'b0, 1'b1, 8'h00, "post_rst_r");
    check("post_rst sdout", 32'(s_dout), 32'hC3);
    check("post_rst empty", 32'(s_empty), 32'd1);

    we = 1'b0; re = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
